// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   state_t          : FSM states (RUN, TRAP)
//   sel_t            : next-PC source selected each cycle
//   DEF_RESET_VECTOR : default PC after reset
//   DEF_EXC_VECTOR   : default PC on trap entry
//   JIDX_W           : width of the J-format instruction index field
package pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        JR   = 3'd3,
        EXC  = 3'd4,
        ERET = 3'd5,
        HOLD = 3'd6
    } sel_t;

    localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEF_EXC_VECTOR   = 64'h80;
    localparam int          JIDX_W           = 26;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and PC outputs of the program-counter unit.
//   master : drives en/br_take/br_offset/jmp/jmp_index/jr/jr_target/exc/eret,
//            observes pc/pc_plus4/epc/in_trap/misalign
//   slave  : the pc_unit side of the same signals
interface pc_unit_if #(
    parameter int AW = 32
);
    import pc_pkg::*;

    logic              en;
    logic              br_take;
    logic [AW-1:0]     br_offset;
    logic              jmp;
    logic [JIDX_W-1:0] jmp_index;
    logic              jr;
    logic [AW-1:0]     jr_target;
    logic              exc;
    logic              eret;
    logic [AW-1:0]     pc;
    logic [AW-1:0]     pc_plus4;
    logic [AW-1:0]     epc;
    logic              in_trap;
    logic              misalign;

    modport master (
        output en, br_take, br_offset, jmp, jmp_index, jr, jr_target, exc, eret,
        input  pc, pc_plus4, epc, in_trap, misalign
    );

    modport slave (
        input  en, br_take, br_offset, jmp, jmp_index, jr, jr_target, exc, eret,
        output pc, pc_plus4, epc, in_trap, misalign
    );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection and target arithmetic.
//   in  : state, pc, epc, en, br_take, br_offset, jmp, jmp_index,
//         jr, jr_target, exc, eret
//   out : sel (chosen source), next_pc, pc_plus4,
//         misalign_evt (enabled jr to a non word-aligned target)
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int            AW     = 32,
    parameter logic [AW-1:0] EXC_PC = '0
) (
    input  state_t            state,
    input  logic [AW-1:0]     pc,
    input  logic [AW-1:0]     epc,
    input  logic              en,
    input  logic              br_take,
    input  logic [AW-1:0]     br_offset,
    input  logic              jmp,
    input  logic [JIDX_W-1:0] jmp_index,
    input  logic              jr,
    input  logic [AW-1:0]     jr_target,
    input  logic              exc,
    input  logic              eret,
    output sel_t              sel,
    output logic [AW-1:0]     next_pc,
    output logic [AW-1:0]     pc_plus4,
    output logic              misalign_evt
);

    // Jump keeps the region bits above bit 27 of pc+4 and replaces the rest.
    localparam logic [AW-1:0] HI_MASK = {{(AW-28){1'b1}}, 28'h0};

    logic [AW-1:0] br_target;
    logic [AW-1:0] jmp_target;

    assign pc_plus4     = pc + AW'(4);
    assign br_target    = pc_plus4 + (br_offset << 2);
    assign jmp_target   = (pc_plus4 & HI_MASK) | AW'({jmp_index, 2'b00});
    assign misalign_evt = en && jr && (jr_target[1:0] != 2'b00);

    // Strict priority; a misaligned jr is handled exactly like an exception.
    always_comb begin
        sel = SEQ;
        if (exc || misalign_evt)        sel = EXC;
        else if (eret && state == TRAP) sel = ERET;
        else if (!en)                   sel = HOLD;
        else if (jr)                    sel = JR;
        else if (jmp)                   sel = JMP;
        else if (br_take)               sel = BR;
        else                            sel = SEQ;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            EXC:     next_pc = EXC_PC;
            ERET:    next_pc = epc;
            HOLD:    next_pc = pc;
            JR:      next_pc = jr_target;
            JMP:     next_pc = jmp_target;
            BR:      next_pc = br_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/register-jump redirects and a
// two-state RUN/TRAP exception FSM.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_unit_if.slave (controls in; pc, pc_plus4, epc, in_trap,
//              misalign out). pc, epc, in_trap and misalign are registered;
//              pc_plus4 is combinational from pc.
// Parameters: WIDTH (AW = 2**WIDTH, 5 or 6), RESET_VECTOR, EXC_VECTOR
// (both truncated to AW bits).
//
// state | meaning
// RUN   | normal sequencing; exception entry saves pc into epc
// TRAP  | handler executing; sequencing continues, nested exceptions
//       | re-vector without touching epc, eret returns to epc
module pc_unit
    import pc_pkg::*;
#(
    parameter int          WIDTH        = 5,
    parameter logic [63:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [63:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);

    localparam int            AW     = 2 ** WIDTH;
    localparam logic [AW-1:0] RST_PC = AW'(RESET_VECTOR);
    localparam logic [AW-1:0] EXC_PC = AW'(EXC_VECTOR);

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] epc;
    logic          in_trap;
    logic          misalign;

    sel_t          sel;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] pc_plus4;
    logic          misalign_evt;

    pc_next_sel #(
        .AW     (AW),
        .EXC_PC (EXC_PC)
    ) u_next_sel (
        .state        (state),
        .pc           (pc),
        .epc          (epc),
        .en           (bus.en),
        .br_take      (bus.br_take),
        .br_offset    (bus.br_offset),
        .jmp          (bus.jmp),
        .jmp_index    (bus.jmp_index),
        .jr           (bus.jr),
        .jr_target    (bus.jr_target),
        .exc          (bus.exc),
        .eret         (bus.eret),
        .sel          (sel),
        .next_pc      (next_pc),
        .pc_plus4     (pc_plus4),
        .misalign_evt (misalign_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RST_PC;
            epc      <= '0;
            state    <= RUN;
            in_trap  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc <= next_pc;
            // Flag only when the misaligned jr itself caused the trap.
            misalign <= misalign_evt && !bus.exc;
            case (sel)
                EXC: begin
                    if (state == RUN) epc <= pc;
                    state   <= TRAP;
                    in_trap <= 1'b1;
                end
                ERET: begin
                    state   <= RUN;
                    in_trap <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pc       = pc;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.epc      = epc;
    assign bus.in_trap  = in_trap;
    assign bus.misalign = misalign;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed bench for pc_unit (WIDTH=5, RESET_VECTOR='h400,
// EXC_VECTOR='h80). Each step pushes the expected post-edge state into a
// scoreboard queue; after the edge the entries are popped and compared.
module tb_pc_unit;

    localparam int AW = 32;

    typedef struct {
        string         tag;
        logic [AW-1:0] pc;
        logic [AW-1:0] epc;
        logic          in_trap;
        logic          misalign;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    pc_unit_if #(.AW(AW)) bus ();

    pc_unit #(
        .WIDTH        (5),
        .RESET_VECTOR (64'h400),
        .EXC_VECTOR   (64'h80)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] req);
        n_tests++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic idle();
        bus.en        = 1'b1;
        bus.br_take   = 1'b0;
        bus.br_offset = '0;
        bus.jmp       = 1'b0;
        bus.jmp_index = '0;
        bus.jr        = 1'b0;
        bus.jr_target = '0;
        bus.exc       = 1'b0;
        bus.eret      = 1'b0;
    endtask

    task automatic step(input string tag, input logic [AW-1:0] pc_e, input logic [AW-1:0] epc_e,
                        input logic trap_e, input logic mis_e);
        exp_t e;
        exp_t got;
        e.tag      = tag;
        e.pc       = pc_e;
        e.epc      = epc_e;
        e.in_trap  = trap_e;
        e.misalign = mis_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            got = sb.pop_front();
            check({got.tag, ".pc"},       bus.pc,       got.pc);
            check({got.tag, ".pc_plus4"}, bus.pc_plus4, got.pc + 32'd4);
            check({got.tag, ".epc"},      bus.epc,      got.epc);
            check({got.tag, ".in_trap"},  AW'(bus.in_trap),  AW'(got.in_trap));
            check({got.tag, ".misalign"}, AW'(bus.misalign), AW'(got.misalign));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step("reset", 32'h400, 32'h0, 1'b0, 1'b0);

        rst = 1'b0;
        step("seq1", 32'h404, 32'h0, 1'b0, 1'b0);
        step("seq2", 32'h408, 32'h0, 1'b0, 1'b0);
        step("seq3", 32'h40C, 32'h0, 1'b0, 1'b0);

        bus.jr = 1'b1; bus.jr_target = 32'h100;
        step("set100", 32'h100, 32'h0, 1'b0, 1'b0);

        bus.jr = 1'b0;
        bus.jmp = 1'b1; bus.jmp_index = 26'h40;
        bus.br_take = 1'b1; bus.br_offset = 32'hFFFF_FFFF;
        step("jmp_over_br", 32'h100, 32'h0, 1'b0, 1'b0);

        bus.jmp = 1'b0;
        step("br_neg", 32'h100, 32'h0, 1'b0, 1'b0);

        bus.br_offset = 32'd2;
        step("br_pos", 32'h10C, 32'h0, 1'b0, 1'b0);

        bus.br_take = 1'b0;
        bus.jr = 1'b1; bus.jr_target = 32'h200;
        bus.jmp = 1'b1; bus.jmp_index = 26'h40;
        step("jr_over_jmp", 32'h200, 32'h0, 1'b0, 1'b0);

        bus.jmp = 1'b0; bus.jr_target = 32'h20;
        step("set20", 32'h20, 32'h0, 1'b0, 1'b0);

        bus.jr = 1'b0; bus.en = 1'b0;
        bus.br_take = 1'b1; bus.br_offset = 32'd2;
        for (int i = 0; i < 4; i++) step("stall", 32'h20, 32'h0, 1'b0, 1'b0);

        bus.en = 1'b1;
        step("stall_release", 32'h2C, 32'h0, 1'b0, 1'b0);

        bus.br_take = 1'b0; bus.jr = 1'b1; bus.jr_target = 32'h50;
        step("set50", 32'h50, 32'h0, 1'b0, 1'b0);

        bus.jr = 1'b0; bus.en = 1'b0; bus.exc = 1'b1;
        step("exc", 32'h80, 32'h50, 1'b1, 1'b0);

        bus.exc = 1'b0; bus.en = 1'b1;
        step("trap_seq", 32'h84, 32'h50, 1'b1, 1'b0);

        bus.exc = 1'b1;
        step("nested_exc", 32'h80, 32'h50, 1'b1, 1'b0);

        bus.exc = 1'b0; bus.en = 1'b0; bus.eret = 1'b1;
        step("eret", 32'h50, 32'h50, 1'b0, 1'b0);

        bus.en = 1'b1;
        step("eret_in_run", 32'h54, 32'h50, 1'b0, 1'b0);

        bus.eret = 1'b0; bus.jr = 1'b1; bus.jr_target = 32'h10;
        step("set10", 32'h10, 32'h50, 1'b0, 1'b0);

        bus.jr_target = 32'h203;
        step("misalign", 32'h80, 32'h10, 1'b1, 1'b1);

        bus.jr = 1'b0; bus.en = 1'b0;
        step("misalign_clr", 32'h80, 32'h10, 1'b1, 1'b0);

        rst = 1'b1;
        step("rst_in_trap", 32'h400, 32'h0, 1'b0, 1'b0);

        rst = 1'b0; bus.eret = 1'b1;
        step("eret_after_rst_hold", 32'h400, 32'h0, 1'b0, 1'b0);

        bus.en = 1'b1;
        step("eret_after_rst_run", 32'h404, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 5, address width exponent; AW = 2**WIDTH bits; legal values 5..6.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset, truncated to AW bits.
REQ-003 Parameter EXC_VECTOR, default 'h80, PC value loaded on trap entry, truncated to AW bits.
REQ-004 The port list SHALL be as follows; there SHALL be one clock, and reset SHALL be synchronous and active-high:
  clk         in   1      clock, all state updates on rising edge
  rst         in   1      synchronous active-high reset
  en          in   1      advance enable; 0 = stall
  br_take     in   1      conditional branch taken
  br_offset   in   AW     sign-extended word offset
  jmp         in   1      J/JAL
  jmp_index   in   26     instruction index field
  jr          in   1      JR/JALR
  jr_target   in   AW     register target
  exc         in   1      exception request
  eret        in   1      return from exception
  pc          out  AW     current PC (registered)
  pc_plus4    out  AW     pc + 4 (combinational)
  epc         out  AW     exception PC (registered)
  in_trap     out  1      FSM in TRAP state (registered)
  misalign    out  1      one-cycle pulse on misaligned jr target

Function
REQ-005 pc_plus4 SHALL equal pc + 4 mod 2**AW at all times.
REQ-006 Branch target SHALL be pc_plus4 + (br_offset << 2), mod 2**AW.
REQ-007 Jump target SHALL be {pc_plus4[AW-1:28], jmp_index, 2'b00}; when AW < 28, only the low AW bits are used.
REQ-008 On each clk edge without rst, the next state SHALL be chosen by strict priority:
  exc > misaligned jr > eret(TRAP only) > en=0 hold > jr > jmp > br_take > pc_plus4.
REQ-009 exc SHALL load pc<=EXC_VECTOR and enter TRAP regardless of en; epc<=pc only if the state was RUN.
REQ-010 If en=1 and jr=1 with jr_target[1:0]!=0, the block SHALL treat this as exc: misalign=1 for exactly that following cycle, and epc is captured per REQ-009.
REQ-011 eret in TRAP SHALL load pc<=epc and return to RUN regardless of en; eret in RUN SHALL be ignored.
REQ-012 en=0 with no exc/eret/misalign event SHALL hold pc, epc and state unchanged.
REQ-013 The FSM SHALL have two states: RUN (normal sequencing) and TRAP (handler executing); in TRAP, sequencing per REQ-008 continues normally.
REQ-014 A nested exc in TRAP SHALL re-vector pc to EXC_VECTOR, stay in TRAP and leave epc unchanged.
REQ-015 Multiple simultaneous redirect inputs SHALL resolve only by REQ-008; unselected inputs have no effect.
REQ-016 pc, epc, in_trap and misalign SHALL all be registered outputs; a redirect becomes visible on pc one cycle after the sampling edge.

Reset
REQ-017 rst=1 at a clk edge SHALL set pc<=RESET_VECTOR, epc<=0, state<=RUN, in_trap<=0 and misalign<=0, overriding all other inputs.
REQ-018 Reset asserted mid-trap or mid-stall SHALL abort it fully; no epc or trap state survives.

Structure
REQ-019 Package pc_pkg SHALL hold the state enum (RUN, TRAP), the next-PC select enum (SEQ, BR, JMP, JR, EXC, ERET, HOLD) and the default vector constants.
REQ-020 Next-PC selection and target arithmetic SHALL be a combinational sub-module pc_next_sel; pc_unit holds the registers and the FSM.

Verification
REQ-021 Reset: rst=1 with RESET_VECTOR='h400, then 3 cycles with en=1 -> pc='h400, 'h404, 'h408, 'h40C.
REQ-022 Branch/jump priority: pc='h100, jmp=1 with jmp_index='h40, br_take=1 with br_offset=-1 -> next pc='h100 (jump wins); branch alone with br_offset=-1 -> 'h100; with br_offset=2 -> 'h10C.
REQ-023 Stall: en=0 for 4 cycles at pc='h20 with br_take=1 -> pc stays 'h20; on release -> branch target taken.
REQ-024 Trap/return: exc at pc='h50 with en=0 -> pc='h80, epc='h50, in_trap=1; nested exc -> epc still 'h50; eret -> pc='h50, in_trap=0.
REQ-025 Misalign: jr=1 with jr_target='h203 at pc='h10 -> pc='h80, epc='h10, misalign high for exactly 1 cycle.
REQ-026 Reset in TRAP: rst while in_trap=1 -> pc=RESET_VECTOR, epc=0, in_trap=0; eret afterwards is ignored.
